// File: rtl/ysyx_23060208_axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// FSM state encodings and the LFSR step function.
package ysyx_23060208_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE = 2'd0;
  localparam r_state_t R_WAIT = 2'd1;
  localparam r_state_t R_RESP = 2'd2;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_WAIT = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/ysyx_23060208_lfsr8.sv
// 8-bit Fibonacci LFSR seeded with 8'hA5; advances on every enabled cycle.
module ysyx_23060208_lfsr8
  import ysyx_23060208_axil_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = lfsr8_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= 8'hA5;
    else     state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/ysyx_23060208_axil_sram_slv.sv
// AXI4-Lite SRAM responder with independent read/write FSMs and an optional
// pseudo-random response delay of 0..3 cycles.
module ysyx_23060208_axil_sram_slv
  import ysyx_23060208_axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RAND_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [DATA_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int WORDS = 1 << ADDR_DEPTH;
  localparam logic [DATA_WIDTH:0] WIN_END = {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * WORDS);

  function automatic logic in_window(input logic [DATA_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < WIN_END);
  endfunction

  logic [7:0] lfsr;
  logic [5:0] lfsr_unused;
  logic [1:0] delay;

  ysyx_23060208_lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  assign lfsr_unused = lfsr[7:2];
  assign delay = (RAND_DELAY != 0) ? lfsr[1:0] : 2'd0;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  r_state_t              r_state_q, r_state_d;
  logic [1:0]            r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0] r_addr_q, r_addr_d, r_fire_addr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_fire;

  w_state_t              w_state_q, w_state_d;
  logic [1:0]            w_cnt_q, w_cnt_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [DATA_WIDTH-1:0] w_addr_q, w_addr_d, w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_commit;

  // Every channel transfers on a rising edge where valid && ready are both high;
  // readies are forced low during reset, and valid outputs hold until accepted.
  assign arready = (r_state_q == R_IDLE) && !rst;
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (w_state_q == W_IDLE) && !aw_got_q && !rst;
  assign wready  = (w_state_q == W_IDLE) && !w_got_q && !rst;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

  // A zero delay registers the response at the AR handshake itself.
  always_comb begin
    r_state_d   = r_state_q;
    r_cnt_d     = r_cnt_q;
    r_addr_d    = r_addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    r_fire      = 1'b0;
    r_fire_addr = r_addr_q;
    case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        r_addr_d    = araddr;
        r_fire_addr = araddr;
        if (delay == 2'd0) begin
          r_fire    = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d   = delay - 2'd1;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt_q == 2'd0) begin
        r_fire    = 1'b1;
        r_state_d = R_RESP;
      end else begin
        r_cnt_d = r_cnt_q - 2'd1;
      end
      R_RESP: if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    if (r_fire) begin
      if (in_window(r_fire_addr)) begin
        rdata_d = mem_q[r_fire_addr[ADDR_DEPTH+1:2]];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_addr_d = awaddr;
          aw_got_d = 1'b1;
        end
        if (wvalid && wready) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          w_got_d  = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_cnt_d   = delay;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: if (w_cnt_q == 2'd0) begin
        w_commit  = 1'b1;
        bresp_d   = in_window(w_addr_q) ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end else begin
        w_cnt_d = w_cnt_q - 2'd1;
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 2'd0;
      r_addr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      w_state_q <= W_IDLE;
      w_cnt_q   <= 2'd0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= 4'd0;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory is never reset; a reset in the commit cycle drops the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && in_window(w_addr_q)) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem_q[w_addr_q[ADDR_DEPTH+1:2]][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_axil_sram_slv.sv
// Bench for the AXI4-Lite SRAM responder: one zero-delay and one random-delay
// instance, checked against a word-array memory model and a reference LFSR.
module tb_ysyx_23060208_axil_sram_slv;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [3:0]  wstrb  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];
  logic        awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
  logic        arvalid[2], arready[2], rvalid[2], rready[2];

  ysyx_23060208_axil_sram_slv #(.RAND_DELAY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0])
  );

  ysyx_23060208_axil_sram_slv #(.RAND_DELAY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1])
  );

  // ---------------- clock / reset / reference LFSR ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference sequence: taps x^8,x^6,x^5,x^4 are bits 7,5,4,3 (mask 8'hB8).
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  // ---------------- scoreboard ----------------
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rdata;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd1024);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int aw_dly, input int w_dly);
    int aw_c, w_c, last_c, lat, n, hold;
    logic [7:0] aw_l, w_l;
    logic [1:0] dly;
    aw_c = 0; w_c = 0; aw_l = 8'd0; w_l = 8'd0;
    fork
      begin
        int k;
        bit hs;
        k = 0; hs = 1'b0;
        repeat (aw_dly) step();
        awaddr[s] = a; awvalid[s] = 1'b1;
        while (!hs && k < 40) begin
          hs = awready[s]; aw_l = m_lfsr; step(); k++;
        end
        awvalid[s] = 1'b0; aw_c = cyc;
        chk("aw_handshake", 32'(hs), 32'd1);
      end
      begin
        int k;
        bit hs;
        k = 0; hs = 1'b0;
        repeat (w_dly) step();
        wdata[s] = d; wstrb[s] = st; wvalid[s] = 1'b1;
        while (!hs && k < 40) begin
          hs = wready[s]; w_l = m_lfsr; step(); k++;
        end
        wvalid[s] = 1'b0; w_c = cyc;
        chk("w_handshake", 32'(hs), 32'd1);
        if (w_dly < aw_dly) chk("wready_drop", 32'(wready[s]), 32'd0);
      end
    join
    if (aw_c >= w_c) begin last_c = aw_c; dly = aw_l[1:0]; end
    else             begin last_c = w_c;  dly = w_l[1:0];  end
    if (s == 0) dly = 2'd0;
    n = 0;
    while (!bvalid[s] && n < 20) begin step(); n++; end
    lat = cyc - last_c;
    chk("b_latency", 32'(lat), 32'(1 + int'(dly)));
    chk("b_bresp", 32'(bresp[s]), in_win(a) ? 32'd0 : 32'd2);
    chk("aw_blocked", 32'(awready[s]), 32'd0);
    chk("w_blocked", 32'(wready[s]), 32'd0);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      step();
      chk("bvalid_hold", 32'(bvalid[s]), 32'd1);
    end
    bready[s] = 1'b1; step(); bready[s] = 1'b0;
    chk("bvalid_pulse", 32'(bvalid[s]), 32'd0);
    if (in_win(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) ref_mem[s][a[9:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_read(input int s, input logic [31:0] a, input int ar_dly, input int stall);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [7:0]  l;
    logic [1:0]  dly;
    int k, hc, lat;
    bit hs;
    exp_d = in_win(a) ? ref_mem[s][a[9:2]] : 32'd0;
    exp_r = in_win(a) ? 2'b00 : 2'b10;
    k = 0; hs = 1'b0; l = 8'd0;
    repeat (ar_dly) step();
    araddr[s] = a; arvalid[s] = 1'b1;
    while (!hs && k < 40) begin
      hs = arready[s]; l = m_lfsr; step(); k++;
    end
    arvalid[s] = 1'b0; hc = cyc;
    chk("ar_handshake", 32'(hs), 32'd1);
    k = 0;
    while (!rvalid[s] && k < 20) begin step(); k++; end
    dly = (s == 1) ? l[1:0] : 2'd0;
    lat = cyc - hc + 1;
    chk("r_latency", 32'(lat), 32'(1 + int'(dly)));
    if (s == 1) chk("r_latency_range", 32'(lat >= 1 && lat <= 4), 32'd1);
    chk("r_rresp", 32'(rresp[s]), 32'(exp_r));
    chk("r_rdata", rdata[s], exp_d);
    last_rdata = rdata[s];
    repeat (stall) begin
      step();
      chk("rvalid_hold", 32'(rvalid[s]), 32'd1);
      chk("rdata_hold", rdata[s], exp_d);
      chk("arready_busy", 32'(arready[s]), 32'd0);
    end
    rready[s] = 1'b1; step(); rready[s] = 1'b0;
    chk("rvalid_drop", 32'(rvalid[s]), 32'd0);
    chk("arready_back", 32'(arready[s]), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, dat;
    logic [3:0]  st;
    int k;
    for (int s = 0; s < 2; s++) begin
      awaddr[s] = '0; wdata[s] = '0; araddr[s] = '0; wstrb[s] = '0;
      awvalid[s] = 1'b0; wvalid[s] = 1'b0; bready[s] = 1'b0;
      arvalid[s] = 1'b0; rready[s] = 1'b0;
    end

    rst = 1'b1;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      chk("rst_arready", 32'(arready[s]), 32'd0);
      chk("rst_awready", 32'(awready[s]), 32'd0);
      chk("rst_wready", 32'(wready[s]), 32'd0);
      chk("rst_bvalid", 32'(bvalid[s]), 32'd0);
      chk("rst_rvalid", 32'(rvalid[s]), 32'd0);
      chk("rst_bresp", 32'(bresp[s]), 32'd0);
      chk("rst_rresp", 32'(rresp[s]), 32'd0);
      chk("rst_rdata", rdata[s], 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("post_rst_arready", 32'(arready[s]), 32'd1);
      chk("post_rst_awready", 32'(awready[s]), 32'd1);
      chk("post_rst_wready", 32'(wready[s]), 32'd1);
    end
    step();

    // Directed scenarios on the zero-delay instance.
    do_write(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(0, BASE + 32'h10, 0, 0);
    chk("full_word", last_rdata, 32'hDEAD_BEEF);
    do_write(0, BASE + 32'h10, 32'h1122_3344, 4'b0101, 0, 0);
    do_read(0, BASE + 32'h10, 0, 0);
    chk("byte_strobe", last_rdata, 32'hDE22_BE44);
    do_write(0, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 3, 0);
    do_read(0, BASE + 32'h20, 0, 0);
    chk("w_before_aw", last_rdata, 32'hCAFE_F00D);
    do_write(0, BASE + 32'h24, 32'h0BAD_F00D, 4'hF, 0, 2);
    do_read(0, BASE + 32'h24, 0, 1);
    do_write(0, BASE, 32'h0123_4567, 4'hF, 0, 0);
    do_read(0, 32'h9000_0000, 0, 0);
    do_write(0, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_read(0, BASE, 0, 0);
    chk("slverr_no_write", last_rdata, 32'h0123_4567);
    do_read(0, BASE + 32'h10, 0, 5);
    // Read registering data on the very edge the write commits sees old data.
    do_write(0, BASE + 32'h30, 32'h55AA_55AA, 4'hF, 0, 0);
    fork
      do_write(0, BASE + 32'h30, 32'h0F0F_0F0F, 4'hF, 0, 0);
      do_read(0, BASE + 32'h30, 1, 0);
    join
    chk("collision_old", last_rdata, 32'h55AA_55AA);
    do_read(0, BASE + 32'h30, 0, 0);
    chk("collision_new", last_rdata, 32'h0F0F_0F0F);

    // Random-delay instance: fill memory, then mixed random traffic.
    for (int i = 0; i < 256; i++) begin
      dat = $urandom;
      do_write(1, BASE + 32'(i * 4), dat, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) a = BASE - 32'(4 * $urandom_range(1, 64));
        else                           a = BASE + 32'd1024 + 32'($urandom_range(0, 4095));
      end else begin
        a = BASE + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      end
      dat = $urandom;
      st  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(1, a, dat, st, $urandom_range(0, 3), $urandom_range(0, 3));
      else                           do_read(1, a, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while a read sits in its wait phase: no response may appear.
    k = 0;
    while ((m_lfsr[1:0] != 2'd3 || !arready[1]) && k < 300) begin step(); k++; end
    chk("abort_setup", 32'(m_lfsr[1:0]), 32'd3);
    araddr[1] = BASE + 32'h8; arvalid[1] = 1'b1;
    step();
    arvalid[1] = 1'b0;
    chk("abort_wait_rvalid", 32'(rvalid[1]), 32'd0);
    chk("abort_wait_arready", 32'(arready[1]), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      step();
      chk("abort_rst_rvalid", 32'(rvalid[1]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("abort_arready", 32'(arready[1]), 32'd1);
    repeat (6) begin
      step();
      chk("abort_no_rvalid", 32'(rvalid[1]), 32'd0);
    end
    do_read(1, BASE + 32'h8, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_axil_sram_slv.md
YSYX_23060208_AXIL_SRAM_SLV -- requirements
Module: ysyx_23060208_axil_sram_slv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data/address bus width.
REQ-002 SHALL have parameter ADDR_DEPTH, default 8: log2 of word count (256 words).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000: base of the decoded window, size 4*2^ADDR_DEPTH bytes.
REQ-004 SHALL have parameter RAND_DELAY, default 1: 1 = LFSR response delay, 0 = zero delay.
REQ-005 SHALL have a single clock and synchronous active-high reset: clk input 1 (rising edge); rst input 1.
REQ-006 SHALL have the AW ports: awaddr input DATA_WIDTH; awvalid input 1; awready output 1.
REQ-007 SHALL have the W ports: wdata input DATA_WIDTH; wstrb input 4, byte enables; wvalid input 1; wready output 1.
REQ-008 SHALL have the B ports: bresp output 2; bvalid output 1; bready input 1.
REQ-009 SHALL have the AR ports: araddr input DATA_WIDTH; arvalid input 1; arready output 1.
REQ-010 SHALL have the R ports: rdata output DATA_WIDTH; rresp output 2; rvalid output 1; rready input 1.

Function
REQ-011 SHALL be an AXI4-Lite responder; a transfer completes on any cycle with valid&&ready high; read and write channels independent.
REQ-012 SHALL run read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE; arready=1 only in R_IDLE.
REQ-013 SHALL on an AR handshake in cycle N latch araddr, load delay d, then enter R_WAIT.
REQ-014 SHALL decrement d in R_WAIT and at d==0 move to R_RESP, registering rdata/rresp, so rvalid first rises in cycle N+1+d.
REQ-015 SHALL hold rvalid, rdata, rresp stable until rready; return to R_IDLE the cycle after the R handshake.
REQ-016 SHALL run write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE; in W_IDLE awready=1 until AW captured, wready=1 until W captured; AW and W in either order or same cycle.
REQ-017 SHALL enter W_WAIT in the cycle after both AW and W are captured, loading d.
REQ-018 SHALL, on W_WAIT reaching d==0, commit bytes with wstrb[i]=1 and enter W_RESP (bvalid=1), holding bvalid until bready.
REQ-019 SHALL index words by addr[ADDR_DEPTH+1:2] and ignore addr[1:0].
REQ-020 SHALL treat an address outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_DEPTH) as SLVERR (2'b10): rdata=0, no memory write; in-range responses SHALL be OKAY (2'b00).
REQ-021 SHALL give d = lfsr[1:0] (0..3) when RAND_DELAY=1, else d=0.
REQ-022 SHALL use an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) that advances every cycle.
REQ-023 SHALL return pre-write data when a write commits to the same word in the same cycle the read registers rdata.
REQ-024 SHALL not accept a new AR while in R_WAIT/R_RESP, nor a new AW/W while in W_WAIT/W_RESP (single outstanding per channel).

Reset
REQ-025 SHALL while rst=1 drive awready, wready, arready, bvalid, rvalid = 0, bresp = rresp = 2'b00, rdata = 0, with both FSMs in IDLE and the LFSR at 8'hA5.
REQ-026 SHALL assert arready, awready and wready in the first cycle after rst deasserts.
REQ-027 SHALL abort any in-flight transaction on reset mid-operation without a response or memory write; memory contents are not reset.

Structure
REQ-028 SHALL take from shared package ysyx_23060208_axil_pkg the RESP_OKAY/RESP_SLVERR constants and the read/write FSM state typedefs.
REQ-029 SHALL instantiate the LFSR as sub-module ysyx_23060208_lfsr8 (ports clk, rst, en, q[7:0]).
REQ-030 SHALL implement memory as a register array, with no vendor macros.

Verification
REQ-031 SHALL with RAND_DELAY=0, write 0x8000_0010 data 0xDEADBEEF wstrb 4'hF, then read it -> bresp 00, rvalid at N+1, rdata 0xDEADBEEF.
REQ-032 SHALL with that word preset to 0xDEADBEEF, write wstrb 4'b0101 data 0x11223344, then read -> rdata 0xDE22BE44.
REQ-033 SHALL with W presented 3 cycles before AW -> wready drops after the W handshake, one bvalid pulse follows the AW handshake, and memory is updated.
REQ-034 SHALL on a read of 0x9000_0000 -> rresp 10, rdata 0; on a write there -> bresp 10, memory unchanged.
REQ-035 SHALL with rready held low 5 cycles -> rvalid/rdata stable and arready=0 throughout.
REQ-036 SHALL with RAND_DELAY=1 and 1000 random transactions checked against a reference model -> every latency in 1..4 cycles, and rst asserted mid-R_WAIT yields no rvalid.
